// File: rtl/dbus_pkg.sv
// Shared constants, FSM state encoding and helpers for the data-bus interconnect.
package dbus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 8;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dbus_addr_decode.sv
// Combinational address decoder: per-slave hit vector plus the highest-index hit.
module dbus_addr_decode
  import dbus_pkg::*;
#(
  parameter int                        NSLAVES    = 2,
  parameter logic [NSLAVES*ADDR_W-1:0] SLAVE_BASE = {16'hFFFE, 16'h0000},
  parameter logic [NSLAVES*ADDR_W-1:0] SLAVE_MASK = {16'hFFFE, 16'h0000}
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [NSLAVES-1:0] o_hit,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Ascending scan: a later (higher-index) hit overwrites an earlier one.
  always_comb begin
    o_hit   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NSLAVES; k++) begin
      o_hit[k] = (i_addr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) == SLAVE_BASE[k*ADDR_W +: ADDR_W];
      if (o_hit[k]) begin
        o_idx   = IDX_W'(k);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbus_interconnect.sv
// Single-master, multi-slave data-bus interconnect with address decode,
// wait-state timeout and bus-error reporting.
module dbus_interconnect
  import dbus_pkg::*;
#(
  parameter int                        NSLAVES    = 2,
  parameter logic [NSLAVES*ADDR_W-1:0] SLAVE_BASE = {16'hFFFE, 16'h0000},
  parameter logic [NSLAVES*ADDR_W-1:0] SLAVE_MASK = {16'hFFFE, 16'h0000},
  parameter int                        TIMEOUT    = 15,
  parameter logic [DATA_W-1:0]         ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [ADDR_W-1:0]           i_m_addr,
  input  logic [DATA_W-1:0]           i_m_dat,
  input  logic                        i_m_we,
  input  logic                        i_m_cs,
  output logic [DATA_W-1:0]           o_m_dat,
  output logic                        o_m_ack,
  output logic                        o_m_err,
  output logic [ADDR_W-1:0]           o_s_addr,
  output logic [DATA_W-1:0]           o_s_dat,
  output logic                        o_s_we,
  output logic [NSLAVES-1:0]          o_s_cs,
  input  logic [NSLAVES*DATA_W-1:0]   i_s_dat,
  input  logic [NSLAVES-1:0]          i_s_ack,
  output logic [ADDR_W-1:0]           o_err_addr,
  output logic                        o_err_irq
);

  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT);

  state_e              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [IDX_W-1:0]    lat_idx;
  logic [NSLAVES-1:0]  dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_valid;
  logic [NSLAVES-1:0]  eff_sel;
  logic [DATA_W-1:0]   sel_dat;
  logic                sel_ack;
  logic                to_hit;

  dbus_addr_decode #(
    .NSLAVES   (NSLAVES),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_decode (
    .i_addr (i_m_addr),
    .o_hit  (dec_hit),
    .o_idx  (dec_idx),
    .o_valid(dec_valid)
  );

  // The effective slave is the live decode in IDLE and the latched one in BUSY.
  always_comb begin
    eff_sel = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      case (state)
        IDLE:    eff_sel[k] = i_m_cs && dec_hit[k] && (dec_idx == IDX_W'(k));
        BUSY:    eff_sel[k] = i_m_cs && (lat_idx == IDX_W'(k));
        default: eff_sel[k] = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (eff_sel[k]) sel_dat = i_s_dat[k*DATA_W +: DATA_W];
    end
  end

  assign sel_ack   = |(eff_sel & i_s_ack);
  assign to_hit    = ({1'b0, wait_cnt} + (CNT_W+1)'(1)) >= TO_LIM;

  assign o_s_addr  = i_m_addr;
  assign o_s_dat   = i_m_dat;
  assign o_s_we    = i_m_we;
  assign o_s_cs    = eff_sel;
  assign o_m_ack   = (state == ERR) || sel_ack;
  assign o_m_err   = (state == ERR);
  assign o_err_irq = (state == ERR);
  assign o_m_dat   = (state == ERR) ? ERR_DATA : sel_dat;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_idx    <= '0;
      o_err_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_m_cs) begin
            if (!dec_valid) begin
              state <= ERR;
            end else if (!sel_ack) begin
              lat_idx  <= dec_idx;
              wait_cnt <= '0;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          // A dropped chip select abandons the access silently; ack beats timeout.
          if (!i_m_cs || sel_ack) begin
            state <= IDLE;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
            if (to_hit) state <= ERR;
          end
        end
        ERR: begin
          o_err_addr <= i_m_addr;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_interconnect.sv
// Randomized scoreboard bench for dbus_interconnect: a 2-slave default instance
// and a 3-slave instance with an unmapped hole and a short timeout.
module tb_dbus_interconnect;

  typedef struct {
    int          cyc;
    bit          err;
    logic [15:0] dat;
    logic [15:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  logic [15:0] m_addr[2];
  logic [15:0] m_wdat[2];
  logic        m_we[2];
  logic        m_cs[2];
  logic [1:0]  sack_a;
  logic [31:0] sdat_a;
  logic [2:0]  sack_b;
  logic [47:0] sdat_b;

  logic [15:0] m_dat_o[2];
  logic [15:0] s_addr_o[2];
  logic [15:0] s_dat_o[2];
  logic [15:0] err_addr_o[2];
  logic        m_ack_o[2];
  logic        m_err_o[2];
  logic        s_we_o[2];
  logic        err_irq_o[2];
  logic [1:0]  cs_a;
  logic [2:0]  cs_b;
  logic [2:0]  s_cs_o[2];

  exp_t        qa[$];
  exp_t        qb[$];
  bit          ea_pend[2];
  logic [15:0] ea_exp[2];

  int n_checks = 0;
  int n_pass   = 0;

  assign s_cs_o[0] = {1'b0, cs_a};
  assign s_cs_o[1] = cs_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_interconnect dut_a (
    .i_clk(clk), .i_reset(rst_n),
    .i_m_addr(m_addr[0]), .i_m_dat(m_wdat[0]), .i_m_we(m_we[0]), .i_m_cs(m_cs[0]),
    .o_m_dat(m_dat_o[0]), .o_m_ack(m_ack_o[0]), .o_m_err(m_err_o[0]),
    .o_s_addr(s_addr_o[0]), .o_s_dat(s_dat_o[0]), .o_s_we(s_we_o[0]), .o_s_cs(cs_a),
    .i_s_dat(sdat_a), .i_s_ack(sack_a),
    .o_err_addr(err_addr_o[0]), .o_err_irq(err_irq_o[0])
  );

  dbus_interconnect #(
    .NSLAVES(3),
    .SLAVE_BASE(48'h8000_0001_0000),
    .SLAVE_MASK(48'hF000_0000_C000),
    .TIMEOUT(4)
  ) dut_b (
    .i_clk(clk), .i_reset(rst_n),
    .i_m_addr(m_addr[1]), .i_m_dat(m_wdat[1]), .i_m_we(m_we[1]), .i_m_cs(m_cs[1]),
    .o_m_dat(m_dat_o[1]), .o_m_ack(m_ack_o[1]), .o_m_err(m_err_o[1]),
    .o_s_addr(s_addr_o[1]), .o_s_dat(s_dat_o[1]), .o_s_we(s_we_o[1]), .o_s_cs(cs_b),
    .i_s_dat(sdat_b), .i_s_ack(sack_b),
    .o_err_addr(err_addr_o[1]), .o_err_irq(err_irq_o[1])
  );

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Reference address map, stated as address ranges.
  function automatic int target(input int dd, input logic [15:0] a);
    int t = -1;
    if (dd == 0) begin
      t = (a >= 16'hFFFE) ? 1 : 0;
    end else begin
      if (a < 16'h4000) t = 0;
      if (a >= 16'h8000 && a < 16'h9000) t = 2;
    end
    return t;
  endfunction

  function automatic int tmo(input int dd);
    return (dd == 0) ? 15 : 4;
  endfunction

  function automatic int nslv(input int dd);
    return (dd == 0) ? 2 : 3;
  endfunction

  function automatic logic [15:0] rand_addr(input int dd);
    logic [15:0] a;
    int r;
    a = 16'($urandom);
    r = $urandom_range(0, 3);
    if (dd == 0) begin
      if (r == 0) a = {15'h7FFF, a[0]};
    end else begin
      case (r)
        0: a = {2'b00, a[13:0]};
        1: a = {4'h8, a[11:0]};
        2: a = {2'b01, a[13:0]};
        default: ;
      endcase
    end
    return a;
  endfunction

  task automatic drive_slaves(input int dd, input logic [2:0] ack, input logic [47:0] dat);
    if (dd == 0) begin
      sack_a = ack[1:0];
      sdat_a = dat[31:0];
    end else begin
      sack_b = ack;
      sdat_b = dat;
    end
  endtask

  task automatic idle_cycle();
    m_cs[0] = 1'b0;
    m_cs[1] = 1'b0;
    drive_slaves(0, 3'b000, 48'h0);
    drive_slaves(1, 3'b000, 48'h0);
    @(posedge clk); #1;
  endtask

  // One master access; the target slave acks dly cycles after the first (-1: never).
  task automatic run_txn(input int dd, input logic [15:0] addr, input int dly,
                         input logic [15:0] sdat, input bit spur);
    int t, to, lat;
    bit err;
    exp_t e;
    logic [2:0]  ack, ecs;
    logic [47:0] dat;
    logic        we;
    logic [15:0] wd;
    t  = target(dd, addr);
    to = tmo(dd);
    if (t < 0) begin
      lat = 1; err = 1'b1;
    end else if (dly >= 0 && dly <= to) begin
      lat = dly; err = 1'b0;
    end else begin
      lat = to + 1; err = 1'b1;
    end
    e.cyc = cyc + lat; e.err = err; e.addr = addr;
    e.dat = err ? 16'hDEAD : sdat;
    if (dd == 0) qa.push_back(e); else qb.push_back(e);
    we = 1'($urandom);
    wd = 16'($urandom);
    for (int c = 0; c <= lat; c++) begin
      m_cs[dd] = 1'b1; m_addr[dd] = addr; m_we[dd] = we; m_wdat[dd] = wd;
      dat = 48'({$urandom(), $urandom()});
      ack = 3'b000;
      if (spur) begin
        for (int k = 0; k < nslv(dd); k++)
          if (k != t && $urandom_range(0, 3) == 0) ack[k] = 1'b1;
      end
      if (t >= 0 && c == dly) begin
        ack[t] = 1'b1;
        dat[16*t +: 16] = sdat;
      end
      drive_slaves(dd, ack, dat);
      @(negedge clk);
      ecs = (t < 0 || (err && c == lat)) ? 3'b000 : 3'(1 << t);
      chk("s_cs", s_cs_o[dd] == ecs, 32'(s_cs_o[dd]), 32'(ecs));
      if (c == 0) begin
        chk("s_broadcast", {s_addr_o[dd], s_dat_o[dd], s_we_o[dd]} == {addr, wd, we},
            32'({s_addr_o[dd], s_we_o[dd]}), 32'({addr, we}));
      end
      @(posedge clk); #1;
    end
    m_cs[dd] = 1'b0;
    drive_slaves(dd, 3'b000, 48'h0);
  endtask

  // Access abandoned after `hold` wait cycles; the slave acks only once cs is gone.
  task automatic run_abort(input int dd, input logic [15:0] addr, input int hold);
    int t;
    logic [2:0] ack;
    t = target(dd, addr);
    for (int c = 0; c <= hold; c++) begin
      m_cs[dd] = 1'b1; m_addr[dd] = addr;
      drive_slaves(dd, 3'b000, 48'h0);
      @(posedge clk); #1;
    end
    m_cs[dd] = 1'b0;
    ack = 3'(1 << t);
    drive_slaves(dd, ack, 48'h1111_2222_3333);
    @(negedge clk);
    chk("abort_no_ack", m_ack_o[dd] == 1'b0, 32'(m_ack_o[dd]), 32'h0);
    @(posedge clk); #1;
    drive_slaves(dd, 3'b000, 48'h0);
  endtask

  task automatic mon_dut(input int dd);
    exp_t e;
    bit have, exp_ack;
    have = 1'b0;
    if (dd == 0 && qa.size() > 0) begin have = 1'b1; e = qa[0]; end
    if (dd == 1 && qb.size() > 0) begin have = 1'b1; e = qb[0]; end
    if (ea_pend[dd]) begin
      chk("err_addr", err_addr_o[dd] == ea_exp[dd], 32'(err_addr_o[dd]), 32'(ea_exp[dd]));
      ea_pend[dd] = 1'b0;
    end
    exp_ack = have && (cyc >= e.cyc);
    if (m_ack_o[dd] || exp_ack) begin
      chk("ack_present", m_ack_o[dd] == exp_ack, 32'(m_ack_o[dd]), 32'(exp_ack));
      if (exp_ack) begin
        if (dd == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        if (m_ack_o[dd]) begin
          chk("rsp_data", m_dat_o[dd] == e.dat, 32'(m_dat_o[dd]), 32'(e.dat));
          chk("rsp_err", m_err_o[dd] == e.err, 32'(m_err_o[dd]), 32'(e.err));
          chk("rsp_irq", err_irq_o[dd] == e.err, 32'(err_irq_o[dd]), 32'(e.err));
        end
        if (e.err) begin
          ea_pend[dd] = 1'b1;
          ea_exp[dd]  = e.addr;
        end
      end
    end else begin
      chk("err_idle", {m_err_o[dd], err_irq_o[dd]} == 2'b00,
          32'({m_err_o[dd], err_irq_o[dd]}), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_dut(0);
      mon_dut(1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly;
    logic [15:0] a;
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = '0; m_wdat[d] = '0; m_we[d] = 1'b0; m_cs[d] = 1'b0;
      ea_pend[d] = 1'b0; ea_exp[d] = '0;
    end
    drive_slaves(0, 3'b000, 48'h0);
    drive_slaves(1, 3'b000, 48'h0);
    m_cs[0] = 1'b1; m_addr[0] = 16'h1234;

    // Reset state, with the decode still live on dut_a.
    repeat (2) @(negedge clk);
    chk("rst_s_cs_a", s_cs_o[0] == 3'b001, 32'(s_cs_o[0]), 32'h1);
    chk("rst_s_cs_b", s_cs_o[1] == 3'b000, 32'(s_cs_o[1]), 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk("rst_flags", {m_ack_o[d], m_err_o[d], err_irq_o[d]} == 3'b000,
          32'({m_ack_o[d], m_err_o[d], err_irq_o[d]}), 32'h0);
      chk("rst_err_addr", err_addr_o[d] == 16'h0000, 32'(err_addr_o[d]), 32'h0);
    end
    m_cs[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios.
    run_txn(0, 16'h1234, 0, 16'hBEEF, 1'b0);
    run_txn(0, 16'hFFFF, 3, 16'h0041, 1'b0);
    run_txn(0, 16'h0002, 15, 16'h5AA5, 1'b1);
    run_txn(0, 16'h5A5A, -1, 16'h0000, 1'b1);
    run_txn(1, 16'h1000, -1, 16'h0000, 1'b0);
    run_txn(1, 16'h4000, 0, 16'hCAFE, 1'b1);
    run_txn(1, 16'h8123, 4, 16'h0BAD, 1'b1);
    run_txn(1, 16'h8FFF, 5, 16'h0BAD, 1'b0);
    run_txn(0, 16'hFFFE, 16, 16'h1357, 1'b1);
    run_abort(1, 16'h0ABC, 3);
    run_txn(1, 16'h0ABC, 0, 16'h2468, 1'b0);
    run_abort(0, 16'hFFFF, 6);
    run_txn(0, 16'hFFFF, 2, 16'h9ABC, 1'b1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 30; i++) begin
      for (int d = 0; d < 2; d++) begin
        a = rand_addr(d);
        dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, tmo(d) + 2));
        run_txn(d, a, dly, 16'($urandom), 1'b1);
        if ($urandom_range(0, 2) == 0) idle_cycle();
      end
    end

    // Reset pulse in the middle of a wait-stated access.
    run_txn(0, 16'h0100, -1, 16'h0000, 1'b0);
    m_cs[0] = 1'b1; m_addr[0] = 16'hFFFF;
    drive_slaves(0, 3'b000, 48'h0);
    repeat (2) begin @(posedge clk); #1; end
    drive_slaves(0, 3'b001, 48'h0000_0000_7777);
    rst_n = 1'b0;
    #1;
    chk("midrst_err_addr", err_addr_o[0] == 16'h0000, 32'(err_addr_o[0]), 32'h0);
    chk("midrst_s_cs", s_cs_o[0] == 3'b010, 32'(s_cs_o[0]), 32'h2);
    chk("midrst_flags", {m_ack_o[0], m_err_o[0], err_irq_o[0]} == 3'b000,
        32'({m_ack_o[0], m_err_o[0], err_irq_o[0]}), 32'h0);
    @(posedge clk); #1;
    m_cs[0] = 1'b0;
    drive_slaves(0, 3'b000, 48'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(0, 16'hFFFE, 1, 16'h7777, 1'b1);
    run_txn(0, 16'h0042, 0, 16'h4242, 1'b1);

    repeat (4) idle_cycle();
    chk("queue_drained", (qa.size() + qb.size()) == 0, 32'(qa.size() + qb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
